// File: rtl/mem_copy_dma_if.sv
// Control and memory-port bundle for the word-wise memory copy engine.
// The master side is the requester plus the memory; the slave side is the copy engine.
interface mem_copy_dma_if #(
    parameter int LEN_WIDTH = 16
);
    // Request/complete protocol: start is a level sampled only while idle, so the
    // requester holds src/dst/len with it. Exactly one of done or aborted then
    // pulses for one cycle per accepted request. A reset mid-copy produces neither.
    // Memory port 2 is a combinational read port. Port 1 writes the bytes selected
    // by mem_wenable_1 at the clock edge.
    logic                 start;
    logic                 abort;
    logic [31:0]          src;
    logic [31:0]          dst;
    logic [LEN_WIDTH-1:0] len;
    logic                 busy;
    logic                 done;
    logic                 aborted;
    logic [31:0]          mem_addr_1;
    logic [31:0]          mem_wdata_1;
    logic [3:0]           mem_wenable_1;
    logic [31:0]          mem_addr_2;
    logic [31:0]          mem_rdata_2;

    modport slave (
        input  start, abort, src, dst, len, mem_rdata_2,
        output busy, done, aborted, mem_addr_1, mem_wdata_1, mem_wenable_1, mem_addr_2
    );

    modport master (
        output start, abort, src, dst, len, mem_rdata_2,
        input  busy, done, aborted, mem_addr_1, mem_wdata_1, mem_wenable_1, mem_addr_2
    );
endinterface

// File: rtl/mem_copy_dma.sv
// Word-per-cycle memory copy engine: reads through port 2 and writes through port 1 in the same cycle,
// in ascending address order, with byte enables trimming the final partial word.
module mem_copy_dma #(
    parameter int LEN_WIDTH = 16
) (
    input  logic                clk,
    input  logic                rst,
    mem_copy_dma_if.slave       bus,
    output logic [1:0]          dbg_state
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_COPY = 2'd1,
        ST_FIN  = 2'd2
    } state_e;

    localparam logic [LEN_WIDTH-1:0] WORD_BYTES = LEN_WIDTH'(4);

    state_e               state_q, state_d;
    logic [31:0]          src_ptr_q, src_ptr_d;
    logic [31:0]          dst_ptr_q, dst_ptr_d;
    logic [LEN_WIDTH-1:0] rem_q, rem_d;
    logic                 aborted_q, aborted_d;

    logic                 busy;
    logic                 done;
    logic [31:0]          mem_addr_1;
    logic [31:0]          mem_wdata_1;
    logic [3:0]           mem_wenable_1;
    logic [31:0]          mem_addr_2;
    logic [3:0]           byte_mask;
    logic [LEN_WIDTH-1:0] step;

    // Addresses are word aligned by construction, so the low bits never matter.
    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^{bus.src[1:0], bus.dst[1:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            src_ptr_q <= '0;
            dst_ptr_q <= '0;
            rem_q     <= '0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            src_ptr_q <= src_ptr_d;
            dst_ptr_q <= dst_ptr_d;
            rem_q     <= rem_d;
            aborted_q <= aborted_d;
        end
    end

    // Byte enables and counter step for the word at the current pointers.
    always_comb begin
        byte_mask = 4'b1111;
        step      = WORD_BYTES;
        if (rem_q < WORD_BYTES) begin
            step = rem_q;
            unique case (rem_q[1:0])
                2'd1:    byte_mask = 4'b0001;
                2'd2:    byte_mask = 4'b0011;
                2'd3:    byte_mask = 4'b0111;
                default: byte_mask = 4'b0000;
            endcase
        end
    end

    always_comb begin
        state_d       = state_q;
        src_ptr_d     = src_ptr_q;
        dst_ptr_d     = dst_ptr_q;
        rem_d         = rem_q;
        aborted_d     = 1'b0;
        busy          = 1'b0;
        done          = 1'b0;
        mem_addr_1    = '0;
        mem_addr_2    = '0;
        mem_wdata_1   = '0;
        mem_wenable_1 = '0;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    if (bus.len != '0) begin
                        src_ptr_d = {bus.src[31:2], 2'b00};
                        dst_ptr_d = {bus.dst[31:2], 2'b00};
                        rem_d     = bus.len;
                        state_d   = ST_COPY;
                    end else begin
                        state_d = ST_FIN;
                    end
                end
            end

            ST_COPY: begin
                busy        = 1'b1;
                mem_addr_2  = src_ptr_q;
                mem_addr_1  = dst_ptr_q;
                mem_wdata_1 = bus.mem_rdata_2;
                if (bus.abort) begin
                    aborted_d = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    mem_wenable_1 = byte_mask;
                    src_ptr_d     = src_ptr_q + 32'd4;
                    dst_ptr_d     = dst_ptr_q + 32'd4;
                    rem_d         = rem_q - step;
                    if (rem_q <= WORD_BYTES) begin
                        state_d = ST_FIN;
                    end
                end
            end

            ST_FIN: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.busy          = busy;
    assign bus.done          = done;
    assign bus.aborted       = aborted_q;
    assign bus.mem_addr_1    = mem_addr_1;
    assign bus.mem_wdata_1   = mem_wdata_1;
    assign bus.mem_wenable_1 = mem_wenable_1;
    assign bus.mem_addr_2    = mem_addr_2;
    assign dbg_state         = state_q;
endmodule

// File: tb/tb_mem_copy_dma.sv
// Randomized bench for mem_copy_dma: a bench-owned memory answers both ports, and a byte-level
// ascending-copy reference memory predicts every cycle's port activity and the final contents.
module tb_mem_copy_dma;
  logic       clk;
  logic       rst;
  logic [1:0] dbg_state;

  mem_copy_dma_if #(.LEN_WIDTH(16)) bus ();

  mem_copy_dma #(.LEN_WIDTH(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- bench memory ----------------
  logic [31:0] mem     [0:1023];
  logic [31:0] ref_mem [0:1023];
  logic        fill_en;
  logic [31:0] fill_seed;
  logic        poke_en;
  logic [31:0] poke_addr;
  logic [31:0] poke_data;

  function automatic logic [31:0] pat(input int i, input logic [31:0] seed);
    return (seed ^ (32'(i) * 32'h9E3779B9)) + 32'(i);
  endfunction

  always @(posedge clk) begin
    if (fill_en) begin
      for (int i = 0; i < 1024; i++) mem[i] <= pat(i, fill_seed);
    end else if (poke_en) begin
      mem[poke_addr[11:2]] <= poke_data;
    end else begin
      for (int b = 0; b < 4; b++)
        if (bus.mem_wenable_1[b])
          mem[bus.mem_addr_1[11:2]][8*b +: 8] <= bus.mem_wdata_1[8*b +: 8];
    end
  end

  assign bus.mem_rdata_2 = mem[bus.mem_addr_2[11:2]];

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [3:0] exp_mask(input int remaining);
    int nbytes;
    nbytes = (remaining >= 4) ? 4 : remaining;
    return 4'((1 << nbytes) - 1);
  endfunction

  task automatic check_quiet(input string tag);
    check({tag, "_busy"},    32'(bus.busy),          32'd0);
    check({tag, "_aborted"}, 32'(bus.aborted),       32'd0);
    check({tag, "_wen"},     32'(bus.mem_wenable_1), 32'd0);
    check({tag, "_addr1"},   bus.mem_addr_1,         32'd0);
    check({tag, "_addr2"},   bus.mem_addr_2,         32'd0);
    check({tag, "_wdata"},   bus.mem_wdata_1,        32'd0);
  endtask

  task automatic mem_compare(input string tag);
    int diffs;
    diffs = 0;
    for (int i = 0; i < 1024; i++) begin
      if (mem[i] !== ref_mem[i]) begin
        if (diffs == 0) check({tag, "_word"}, mem[i], ref_mem[i]);
        diffs++;
      end
    end
    check({tag, "_diffs"}, 32'(diffs), 32'd0);
  endtask

  // ---------------- driver tasks (entered and left at posedge + 1) ----------------
  task automatic poke(input logic [31:0] addr, input logic [31:0] data);
    poke_en   = 1'b1;
    poke_addr = addr;
    poke_data = data;
    @(posedge clk); #1;
    poke_en = 1'b0;
    ref_mem[addr[11:2]] = data;
  endtask

  // abort_cyc / rst_cyc: COPY cycle index at which abort / rst is raised, -1 for never.
  task automatic do_copy(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n,
                         input int abort_cyc, input int rst_cyc, input bit noise);
    logic [31:0] sp, dp, exp_data;
    logic [3:0]  exp_wen;
    int          r, ncyc, writes;
    sp = {s[31:2], 2'b00};
    dp = {d[31:2], 2'b00};
    r = int'(n);
    ncyc = (r + 3) / 4;
    writes = 0;

    bus.start = 1'b1;
    bus.src   = s;
    bus.dst   = d;
    bus.len   = n;
    bus.abort = 1'b0;
    @(posedge clk); #1;
    bus.start = 1'b0;

    for (int k = 0; k < ncyc; k++) begin
      if (noise) begin
        bus.src   = $urandom;
        bus.dst   = $urandom;
        bus.len   = 16'($urandom);
        bus.start = 1'($urandom_range(0, 1));
      end
      bus.abort = (k == abort_cyc);
      rst       = (k == rst_cyc);
      #1;
      exp_data = ref_mem[sp[11:2]];
      exp_wen  = (k == abort_cyc) ? 4'h0 : exp_mask(r);
      check("copy_busy",    32'(bus.busy),          32'd1);
      check("copy_done",    32'(bus.done),          32'd0);
      check("copy_aborted", 32'(bus.aborted),       32'd0);
      check("copy_addr2",   bus.mem_addr_2,         sp);
      check("copy_addr1",   bus.mem_addr_1,         dp);
      check("copy_wen",     32'(bus.mem_wenable_1), 32'(exp_wen));
      check("copy_wdata",   bus.mem_wdata_1,        exp_data);
      for (int b = 0; b < 4; b++)
        if (exp_wen[b]) ref_mem[dp[11:2]][8*b +: 8] = exp_data[8*b +: 8];
      if (exp_wen != 4'h0) writes++;

      @(posedge clk); #1;
      bus.start = 1'b0;
      bus.abort = 1'b0;

      if (k == abort_cyc) begin
        check("abort_pulse", 32'(bus.aborted), 32'd1);
        check("abort_busy",  32'(bus.busy),    32'd0);
        check("abort_done",  32'(bus.done),    32'd0);
        check("abort_wen",   32'(bus.mem_wenable_1), 32'd0);
        check("abort_writes", 32'(writes), 32'(abort_cyc));
        @(posedge clk); #1;
        check("abort_done_after", 32'(bus.done), 32'd0);
        check_quiet("abort_after");
        return;
      end

      if (k == rst_cyc) begin
        rst = 1'b0;
        check("rst_done", 32'(bus.done), 32'd0);
        check_quiet("rst");
        @(posedge clk); #1;
        check("rst_done_after", 32'(bus.done), 32'd0);
        check_quiet("rst_after");
        return;
      end

      sp = sp + 32'd4;
      dp = dp + 32'd4;
      r  = r - ((r >= 4) ? 4 : r);
    end

    // Completion cycle: a start here must be ignored.
    if (noise) begin
      bus.start = 1'b1;
      bus.len   = 16'd8;
    end
    #1;
    check("fin_done", 32'(bus.done), 32'd1);
    check_quiet("fin");
    check("fin_writes", 32'(writes), 32'(ncyc));
    @(posedge clk); #1;
    bus.start = 1'b0;
    check("idle_done", 32'(bus.done), 32'd0);
    check_quiet("idle");
  endtask

  // ---------------- main sequence ----------------
  logic [31:0] orig;
  logic [31:0] rs, rd;
  logic [15:0] rn;
  int          ab, rc, nc;

  initial begin
    rst       = 1'b1;
    fill_en   = 1'b1;
    fill_seed = $urandom;
    poke_en   = 1'b0;
    poke_addr = '0;
    poke_data = '0;
    bus.start = 1'b1;
    bus.abort = 1'b1;
    bus.src   = 32'h100;
    bus.dst   = 32'h200;
    bus.len   = 16'd16;
    for (int i = 0; i < 1024; i++) ref_mem[i] = pat(i, fill_seed);
    repeat (2) @(posedge clk);
    #1;
    check("reset_done", 32'(bus.done), 32'd0);
    check_quiet("reset");
    fill_en   = 1'b0;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    rst       = 1'b0;
    @(posedge clk); #1;
    check_quiet("post_reset");

    // Aligned 16-byte copy.
    poke(32'h100, 32'h11111111);
    poke(32'h104, 32'h22222222);
    poke(32'h108, 32'h33333333);
    poke(32'h10C, 32'h44444444);
    do_copy(32'h100, 32'h200, 16'd16, -1, -1, 1'b0);
    mem_compare("full16");

    // Partial tail word keeps the untouched upper bytes.
    poke(32'h300, 32'hFFFFFFFF);
    poke(32'h304, 32'hFFFFFFFF);
    do_copy(32'h100, 32'h300, 16'd6, -1, -1, 1'b0);
    mem_compare("partial6");
    check("partial6_upper", 32'(mem[32'h304 >> 2][31:16]), 32'h0000FFFF);

    // Zero length: straight to completion, no writes.
    do_copy(32'h100, 32'h380, 16'd0, -1, -1, 1'b0);
    mem_compare("len0");

    // Abort in the third copy cycle, then a fresh request.
    do_copy(32'h400, 32'h500, 16'd32, 2, -1, 1'b0);
    mem_compare("abort");
    do_copy(32'h400, 32'h600, 16'd8, -1, -1, 1'b0);
    mem_compare("after_abort");

    // Misaligned addresses with input noise during the copy; then reset mid-copy.
    do_copy(32'h103, 32'h202, 16'd20, -1, -1, 1'b1);
    mem_compare("misalign");
    do_copy(32'h100, 32'h700, 16'd40, -1, 3, 1'b1);
    mem_compare("rst_mid");

    // Overlap: ascending copy smears the first word forward.
    poke(32'h100, 32'hA5A5_0001);
    poke(32'h104, 32'hB6B6_0002);
    poke(32'h108, 32'hC7C7_0003);
    poke(32'h10C, 32'hD8D8_0004);
    orig = 32'hA5A5_0001;
    do_copy(32'h100, 32'h104, 16'd12, -1, -1, 1'b0);
    mem_compare("overlap");
    check("overlap_10c", mem[32'h10C >> 2], orig);

    // Pointer wrap on source and destination.
    do_copy(32'hFFFF_FFF8, 32'h0000_0800, 16'd16, -1, -1, 1'b0);
    mem_compare("wrap_src");
    do_copy(32'h0000_0040, 32'hFFFF_FFF4, 16'd20, -1, -1, 1'b0);
    mem_compare("wrap_dst");

    // Randomized requests.
    for (int t = 0; t < 30; t++) begin
      rs = $urandom;
      rd = $urandom;
      rn = 16'($urandom_range(0, 80));
      nc = (int'(rn) + 3) / 4;
      ab = -1;
      rc = -1;
      if (nc > 0) begin
        if ($urandom_range(0, 3) == 0)      ab = $urandom_range(0, nc - 1);
        else if ($urandom_range(0, 7) == 0) rc = $urandom_range(0, nc - 1);
      end
      do_copy(rs, rd, rn, ab, rc, 1'($urandom_range(0, 1)));
      mem_compare("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
